// File: rtl/rvfi_retire_sequencer.sv
// In-order retire tracker: records issued instructions, collects MEM/WB
// results out of order and emits one RVFI retirement per cycle in issue order.
module rvfi_retire_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  input  logic [31:0]                issue_pc,
  input  logic [31:0]                issue_insn,
  input  logic [4:0]                 issue_rd,
  input  logic                       issue_is_load,
  output logic                       issue_ready,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_pc,
  input  logic [31:0]                mem_result,
  input  logic                       mem_branch_hazard,
  input  logic [31:0]                mem_pc_jump,
  input  logic                       wb_load_valid,
  input  logic [31:0]                wb_pc,
  input  logic [31:0]                wb_data,
  output logic                       rvfi_valid,
  output logic [31:0]                rvfi_insn,
  output logic [31:0]                rvfi_pc_rdata,
  output logic [31:0]                rvfi_pc_wdata,
  output logic [31:0]                rvfi_rd_wdata,
  output logic [4:0]                 rvfi_rd_addr,
  output logic                       overflow_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ISSUED  = 2'd1,
    ST_WAIT_WB = 2'd2,
    ST_DONE    = 2'd3
  } ent_state_e;

  typedef struct packed {
    ent_state_e  st;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] pc_wdata;
    logic [31:0] rd_wdata;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          last_vld_q, last_vld_d;

  logic          rv_valid_q, rv_valid_d;
  logic [31:0]   rv_insn_q, rv_insn_d;
  logic [31:0]   rv_pc_r_q, rv_pc_r_d;
  logic [31:0]   rv_pc_w_q, rv_pc_w_d;
  logic [31:0]   rv_rd_w_q, rv_rd_w_d;
  logic [4:0]    rv_rd_a_q, rv_rd_a_d;

  logic          mem_hit, wb_hit;
  logic [PW-1:0] mem_off, wb_off, mem_idx, wb_idx;
  logic          flush, retire, replay, issue_acc, wb_apply;

  assign issue_ready = (count_q < CW'(DEPTH));

  // Age-ordered search from head for the oldest matching MEM and WB entries.
  always_comb begin
    mem_hit = 1'b0;
    mem_off = '0;
    wb_hit  = 1'b0;
    wb_off  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!mem_hit && mem_valid && ent_q[head_q + PW'(i)].st == ST_ISSUED &&
          ent_q[head_q + PW'(i)].pc == mem_pc) begin
        mem_hit = 1'b1;
        mem_off = PW'(i);
      end
      if (!wb_hit && wb_load_valid && ent_q[head_q + PW'(i)].st == ST_WAIT_WB &&
          ent_q[head_q + PW'(i)].pc == wb_pc) begin
        wb_hit = 1'b1;
        wb_off = PW'(i);
      end
    end
    mem_idx = head_q + mem_off;
    wb_idx  = head_q + wb_off;
  end

  // Control decisions for this cycle; a flush squashes any same-cycle issue.
  always_comb begin
    flush     = mem_hit && mem_branch_hazard;
    retire    = (ent_q[head_q].st == ST_DONE);
    replay    = last_vld_q && (issue_pc == last_pc_q);
    issue_acc = issue_valid && issue_ready && (issue_insn != 32'd0) && !replay && !flush;
    wb_apply  = wb_hit && !(mem_hit && (wb_off == mem_off));
  end

  // Next-state for entries, pointers, sticky error and the retire port.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ovf_d      = ovf_q | (issue_valid && !issue_ready);
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    rv_valid_d = 1'b0;
    rv_insn_d  = 32'd0;
    rv_pc_r_d  = 32'd0;
    rv_pc_w_d  = 32'd0;
    rv_rd_w_d  = 32'd0;
    rv_rd_a_d  = 5'd0;

    if (retire) begin
      rv_valid_d    = 1'b1;
      rv_insn_d     = ent_q[head_q].insn;
      rv_pc_r_d     = ent_q[head_q].pc;
      rv_pc_w_d     = ent_q[head_q].pc_wdata;
      rv_rd_w_d     = ent_q[head_q].rd_wdata;
      rv_rd_a_d     = ent_q[head_q].rd;
      ent_d[head_q] = '0;
      head_d        = head_q + PW'(1);
    end

    if (issue_acc) begin
      ent_d[tail_q].st       = ST_ISSUED;
      ent_d[tail_q].pc       = issue_pc;
      ent_d[tail_q].insn     = issue_insn;
      ent_d[tail_q].rd       = issue_rd;
      ent_d[tail_q].is_load  = issue_is_load;
      ent_d[tail_q].pc_wdata = 32'd0;
      ent_d[tail_q].rd_wdata = 32'd0;
      last_pc_d              = issue_pc;
      last_vld_d             = 1'b1;
    end

    if (wb_apply) begin
      ent_d[wb_idx].st       = ST_DONE;
      ent_d[wb_idx].rd_wdata = wb_data;
    end

    if (mem_hit) begin
      if (ent_q[mem_idx].is_load) begin
        ent_d[mem_idx].st = ST_WAIT_WB;
      end else begin
        ent_d[mem_idx].st       = ST_DONE;
        ent_d[mem_idx].rd_wdata = mem_result;
      end
      ent_d[mem_idx].pc_wdata = mem_branch_hazard ? mem_pc_jump : (ent_q[mem_idx].pc + 32'd4);
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(i) > CW'(mem_off)) && (CW'(i) < count_q)) begin
          ent_d[head_q + PW'(i)] = '0;
        end
      end
      tail_d     = mem_idx + PW'(1);
      count_d    = CW'(mem_off) + CW'(1) - CW'(retire);
      last_vld_d = 1'b0;
    end else begin
      tail_d  = tail_q + PW'(issue_acc);
      count_d = count_q + CW'(issue_acc) - CW'(retire);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      last_pc_q  <= 32'd0;
      last_vld_q <= 1'b0;
      rv_valid_q <= 1'b0;
      rv_insn_q  <= 32'd0;
      rv_pc_r_q  <= 32'd0;
      rv_pc_w_q  <= 32'd0;
      rv_rd_w_q  <= 32'd0;
      rv_rd_a_q  <= 5'd0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
      rv_valid_q <= rv_valid_d;
      rv_insn_q  <= rv_insn_d;
      rv_pc_r_q  <= rv_pc_r_d;
      rv_pc_w_q  <= rv_pc_w_d;
      rv_rd_w_q  <= rv_rd_w_d;
      rv_rd_a_q  <= rv_rd_a_d;
    end
  end

  assign rvfi_valid    = rv_valid_q;
  assign rvfi_insn     = rv_insn_q;
  assign rvfi_pc_rdata = rv_pc_r_q;
  assign rvfi_pc_wdata = rv_pc_w_q;
  assign rvfi_rd_wdata = rv_rd_w_q;
  assign rvfi_rd_addr  = rv_rd_a_q;
  assign overflow_err  = ovf_q;
  assign count         = count_q;

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// Directed vector bench for rvfi_retire_sequencer (DEPTH = 4).
module tb_rvfi_retire_sequencer;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic [31:0] issue_pc, issue_insn;
  logic [4:0]  issue_rd;
  logic        issue_is_load, issue_ready;
  logic        mem_valid;
  logic [31:0] mem_pc, mem_result;
  logic        mem_branch_hazard;
  logic [31:0] mem_pc_jump;
  logic        wb_load_valid;
  logic [31:0] wb_pc, wb_data;
  logic        rvfi_valid;
  logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic        overflow_err;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  int cur_vec  = -1;

  rvfi_retire_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_insn(issue_insn),
    .issue_rd(issue_rd), .issue_is_load(issue_is_load), .issue_ready(issue_ready),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_result(mem_result),
    .mem_branch_hazard(mem_branch_hazard), .mem_pc_jump(mem_pc_jump),
    .wb_load_valid(wb_load_valid), .wb_pc(wb_pc), .wb_data(wb_data),
    .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .overflow_err(overflow_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;  logic [31:0] ipc;  logic [31:0] iinsn; logic [4:0] ird; logic ild;
    logic        mv;  logic [31:0] mpc;  logic [31:0] mres;  logic mhz; logic [31:0] mjmp;
    logic        wv;  logic [31:0] wpc;  logic [31:0] wdat;
    logic        ev;  logic [31:0] epc;  logic [31:0] enpc;  logic [31:0] ewd;
    logic [31:0] einsn; logic [4:0] erd;
    logic [2:0]  ecnt; logic erdy; logic eovf;
  } vec_t;

  localparam int NV = 45;
  vec_t vt [NV];

  localparam logic [31:0] I1  = 32'h0050_0093;
  localparam logic [31:0] L1  = 32'h0000_a103;
  localparam logic [31:0] BR  = 32'h0000_0463;
  localparam logic [31:0] A2  = 32'h0010_0113;
  localparam logic [31:0] A3  = 32'h0020_0193;
  localparam logic [31:0] E1  = 32'h0010_0093;
  localparam logic [31:0] E2  = 32'h0020_0113;
  localparam logic [31:0] E3  = 32'h0030_0193;
  localparam logic [31:0] LD6 = 32'h0000_a183;
  localparam logic [31:0] A6  = 32'h0010_0213;
  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%08h expected=0x%08h", nm, cur_vec, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_pc = 32'h0; issue_insn = 32'h0; issue_rd = 5'd0; issue_is_load = 1'b0;
    mem_valid = 1'b0; mem_pc = 32'h0; mem_result = 32'h0; mem_branch_hazard = 1'b0; mem_pc_jump = 32'h0;
    wb_load_valid = 1'b0; wb_pc = 32'h0; wb_data = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    issue_valid = v.iv; issue_pc = v.ipc; issue_insn = v.iinsn; issue_rd = v.ird; issue_is_load = v.ild;
    mem_valid = v.mv; mem_pc = v.mpc; mem_result = v.mres; mem_branch_hazard = v.mhz; mem_pc_jump = v.mjmp;
    wb_load_valid = v.wv; wb_pc = v.wpc; wb_data = v.wdat;
  endtask

  task automatic check_vec(input vec_t v);
    chk("rvfi_valid", 32'(rvfi_valid), 32'(v.ev));
    chk("rvfi_pc_rdata", rvfi_pc_rdata, v.epc);
    chk("rvfi_pc_wdata", rvfi_pc_wdata, v.enpc);
    chk("rvfi_rd_wdata", rvfi_rd_wdata, v.ewd);
    chk("rvfi_insn", rvfi_insn, v.einsn);
    chk("rvfi_rd_addr", 32'(rvfi_rd_addr), 32'(v.erd));
    chk("count", 32'(count), 32'(v.ecnt));
    chk("issue_ready", 32'(issue_ready), 32'(v.erdy));
    chk("overflow_err", 32'(overflow_err), 32'(v.eovf));
  endtask

  initial begin
    // iv ipc iinsn ird ild | mv mpc mres mhz mjmp | wv wpc wdat | ev epc enpc ewd einsn erd | cnt rdy ovf
    // ADDI single retire
    vt[0]  = '{1'b1,32'h100,I1,5'd1,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[1]  = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h100,32'h5,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[2]  = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h100,32'h104,32'h5,I1,5'd1, 3'd0,1'b1,1'b0};
    vt[3]  = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd0,1'b1,1'b0};
    // load waits for WB
    vt[4]  = '{1'b1,32'h200,L1,5'd2,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[5]  = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h200,32'h1234,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[6]  = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[7]  = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b1,32'h200,32'hDEADBEEF, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[8]  = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h200,32'h204,32'hDEADBEEF,L1,5'd2, 3'd0,1'b1,1'b0};
    // branch hazard flushes younger entries and a same-cycle issue
    vt[9]  = '{1'b1,32'h300,BR,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[10] = '{1'b1,32'h304,A2,5'd2,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[11] = '{1'b1,32'h308,A3,5'd3,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd3,1'b1,1'b0};
    vt[12] = '{1'b1,32'h30c,NOP,5'd0,1'b0, 1'b1,32'h300,32'h0,1'b1,32'h400, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[13] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h300,32'h400,32'h0,BR,5'd0, 3'd0,1'b1,1'b0};
    vt[14] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h304,32'h7,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd0,1'b1,1'b0};
    vt[15] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd0,1'b1,1'b0};
    // replay / zero insn filtering, out-of-order MEM, issue+retire same cycle
    vt[16] = '{1'b1,32'h500,E1,5'd1,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[17] = '{1'b1,32'h500,E1,5'd1,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[18] = '{1'b1,32'h504,32'h0,5'd2,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[19] = '{1'b1,32'h504,E2,5'd2,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[20] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h504,32'h22,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[21] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[22] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h500,32'h11,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[23] = '{1'b1,32'h508,E3,5'd3,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h500,32'h504,32'h11,E1,5'd1, 3'd2,1'b1,1'b0};
    vt[24] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h504,32'h508,32'h22,E2,5'd2, 3'd1,1'b1,1'b0};
    vt[25] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[26] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h508,32'h33,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[27] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h508,32'h50c,32'h33,E3,5'd3, 3'd0,1'b1,1'b0};
    // same-cycle MEM and WB on different entries
    vt[28] = '{1'b1,32'h600,LD6,5'd3,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[29] = '{1'b1,32'h604,A6,5'd4,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[30] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h600,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[31] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h604,32'h44,1'b0,32'h0, 1'b1,32'h600,32'hAAAA5555, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[32] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h600,32'h604,32'hAAAA5555,LD6,5'd3, 3'd1,1'b1,1'b0};
    vt[33] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h604,32'h608,32'h44,A6,5'd4, 3'd0,1'b1,1'b0};
    vt[34] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b1,32'h700,32'h1, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd0,1'b1,1'b0};
    // fill to DEPTH, overflow, full buffer retiring still not ready
    vt[35] = '{1'b1,32'h800,NOP,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd1,1'b1,1'b0};
    vt[36] = '{1'b1,32'h804,NOP,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd2,1'b1,1'b0};
    vt[37] = '{1'b1,32'h808,NOP,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd3,1'b1,1'b0};
    vt[38] = '{1'b1,32'h80c,NOP,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd4,1'b0,1'b0};
    vt[39] = '{1'b1,32'h810,NOP,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd4,1'b0,1'b1};
    vt[40] = '{1'b1,32'h814,NOP,5'd0,1'b0, 1'b1,32'h800,32'h1,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd4,1'b0,1'b1};
    vt[41] = '{1'b1,32'h818,NOP,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h800,32'h804,32'h1,NOP,5'd0, 3'd3,1'b1,1'b1};
    vt[42] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd3,1'b1,1'b1};
    // leave a retire on the outputs with three entries pending
    vt[43] = '{1'b0,32'h0,32'h0,5'd0,1'b0, 1'b1,32'h804,32'h9,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,32'h0,32'h0,32'h0,32'h0,5'd0, 3'd3,1'b1,1'b1};
    vt[44] = '{1'b1,32'h81c,NOP,5'd0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,32'h804,32'h808,32'h9,NOP,5'd0, 3'd3,1'b1,1'b1};

    idle_inputs();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ready", 32'(issue_ready), 32'd1);
    chk("reset_valid", 32'(rvfi_valid), 32'd0);
    chk("reset_ovf", 32'(overflow_err), 32'd0);
    chk("reset_pc_rdata", rvfi_pc_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    @(posedge clk);
    #1;
    for (int k = 0; k < NV; k++) begin
      cur_vec = k;
      apply(vt[k]);
      @(posedge clk);
      #1;
      check_vec(vt[k]);
    end

    // Asynchronous reset while a retire is visible and three entries are in flight.
    cur_vec = 100;
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rvfi_valid), 32'd0);
    chk("async_rst_pc_rdata", rvfi_pc_rdata, 32'd0);
    chk("async_rst_rd_wdata", rvfi_rd_wdata, 32'd0);
    chk("async_rst_insn", rvfi_insn, 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ovf", 32'(overflow_err), 32'd0);
    chk("async_rst_ready", 32'(issue_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cur_vec = 101 + c;
      idle_inputs();
      if (c == 0) begin
        mem_valid = 1'b1; mem_pc = 32'h808; mem_result = 32'h5;
      end
      if (c == 1) begin
        wb_load_valid = 1'b1; wb_pc = 32'h80c; wb_data = 32'h6;
      end
      @(posedge clk);
      #1;
      chk("post_rst_valid", 32'(rvfi_valid), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_sequencer.md
RVFI_RETIRE_SEQUENCER -- requirements
Module: rvfi_retire_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, tracker entries in flight; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port issue_valid, input, 1, ID stage presents an instruction this cycle.
REQ-005 SHALL have ports issue_pc / issue_insn, input, 32/32, ID-stage PC and encoding.
REQ-006 SHALL have ports issue_rd, input, 5 and issue_is_load, input, 1.
REQ-007 SHALL have port issue_ready, output, 1, high when not full.
REQ-008 SHALL have ports mem_valid, input, 1; mem_pc, input, 32; mem_result, input, 32.
REQ-009 SHALL have ports mem_branch_hazard, input, 1 and mem_pc_jump, input, 32.
REQ-010 SHALL have ports wb_load_valid, input, 1; wb_pc, input, 32; wb_data, input, 32.
REQ-011 SHALL have ports rvfi_valid, output, 1; rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata, output, 32 each; rvfi_rd_addr, output, 5.
REQ-012 SHALL have ports overflow_err, output, 1 and count, output, $clog2(DEPTH)+1.

Function
REQ-013 SHALL hold entries in a circular buffer, head/tail pointers wrap modulo DEPTH; count = entries occupied.
REQ-014 Each entry SHALL be in one state: EMPTY, ISSUED, WAIT_WB, DONE.
REQ-015 Issue: issue_valid && issue_ready && issue_insn != 0 && issue_pc != PC of most recent allocation SHALL write tail entry as ISSUED and advance tail.
REQ-016 issue_insn == 0 or repeated PC (stall replay) SHALL be ignored without allocation.
REQ-017 issue_valid while full SHALL drop the instruction and set overflow_err (sticky until reset).
REQ-018 MEM match: mem_valid SHALL update the oldest ISSUED entry whose PC equals mem_pc; none matching -> no effect.
REQ-019 On MEM match, non-load SHALL become DONE with rd_wdata = mem_result; load SHALL become WAIT_WB.
REQ-020 On MEM match with mem_branch_hazard, entry pc_wdata SHALL be mem_pc_jump and all younger entries SHALL be freed same cycle (tail = matched index + 1); otherwise pc_wdata = pc + 4 (mod 2^32).
REQ-021 WB match: wb_load_valid SHALL move the oldest WAIT_WB entry with PC == wb_pc to DONE, rd_wdata = wb_data.
REQ-022 Retire: when head entry is DONE, SHALL register it onto rvfi_* outputs with rvfi_valid = 1 for exactly one cycle, free it, advance head; max one retire per cycle.
REQ-023 rvfi_valid SHALL be 0 in cycles with no retire; rvfi_* data then SHALL be 0.
REQ-024 Latency: entry made DONE at edge N SHALL appear on outputs after edge N+1 if it is head.
REQ-025 Same-cycle issue + retire SHALL both occur; a full buffer retiring this cycle SHALL still report issue_ready = 0 (ready depends only on registered count).
REQ-026 Same-cycle MEM and WB matches on different entries SHALL both apply; on same entry WB SHALL be ignored.
REQ-027 Flush and issue in same cycle SHALL discard the issue (wrong-path).
REQ-028 issue_ready SHALL be combinational: count < DEPTH.

Reset
REQ-029 reset_n low SHALL asynchronously clear all entries to EMPTY, head = tail = count = 0, overflow_err = 0, all rvfi_* = 0, last-allocated PC invalid.
REQ-030 Reset asserted mid-operation SHALL discard in-flight entries with no retire emitted.

Verification
REQ-031 Issue ADDI pc 0x100; MEM match pc 0x100 result 0x5 -> next cycle rvfi_valid=1, pc_rdata 0x100, pc_wdata 0x104, rd_wdata 0x5.
REQ-032 Issue LW pc 0x200 (load), MEM match, then WB pc 0x200 data 0xDEADBEEF -> single retire after WB with rd_wdata 0xDEADBEEF; no retire after MEM.
REQ-033 Issue pcs 0x300,0x304,0x308; MEM 0x300 with hazard, jump 0x400 -> retire 0x300 pc_wdata 0x400; count 0 afterwards; 0x304/0x308 never retire.
REQ-034 DEPTH=4: issue 5 distinct pcs without MEM -> issue_ready 0 after 4th, overflow_err=1, count=4.
REQ-035 Issue 0x500 twice consecutively plus insn 0 -> count=1; out-of-order MEM for younger entry held until head DONE, retire strictly in PC issue order.
REQ-036 Assert reset_n low with 3 entries pending -> outputs 0 immediately, count 0, no later retire.
